// File: rtl/dragon_head_if.sv
// dragon_head_if: frame sync, chase target and hit inputs plus head/counter outputs of dragon_head_ctrl
interface dragon_head_if;
    logic       vsync;
    logic       enable;
    logic [7:0] target_pos;
    logic       hit;
    logic [9:0] Dragon_Head;
    logic [5:0] movementCounter;
    logic       step_pulse;
    logic [1:0] state_out;
    modport master (
        output vsync, enable, target_pos, hit,
        input  Dragon_Head, movementCounter, step_pulse, state_out
    );
    modport slave (
        input  vsync, enable, target_pos, hit,
        output Dragon_Head, movementCounter, step_pulse, state_out
    );
endinterface

// File: rtl/dragon_head_ctrl.sv
// dragon_head_ctrl: steps the dragon head one tile per move period toward (or away from) a target
module dragon_head_ctrl #(
    parameter int GRID_W        = 16,
    parameter int GRID_H        = 12,
    parameter int MOVE_PERIOD   = 10,
    parameter int RETREAT_STEPS = 4,
    parameter int START_X       = 2,
    parameter int START_Y       = 2
) (
    input  logic         clk,
    input  logic         reset,
    dragon_head_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, CHASE = 2'b01, HOLD = 2'b10, RETREAT = 2'b11} state_t;
    localparam logic [1:0] UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3;
    localparam logic [3:0] XMAX = 4'(GRID_W - 1);
    localparam logic [3:0] YMAX = 4'(GRID_H - 1);
    localparam logic [5:0] PERIOD = 6'(MOVE_PERIOD);
    localparam logic [7:0] RSTEPS = 8'(RETREAT_STEPS);

    state_t state_q, state_d, eff;
    logic [1:0] orient_q, orient_d;
    logic [3:0] x_q, x_d, y_q, y_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] rcnt_q, rcnt_d, rcnt_eff;
    logic vsync_d_q, step_pulse_q;
    logic tick, step, retreat, at_target, x_primary, sec_ok, moved, hit_live;
    logic [3:0] tx, ty;
    logic signed [4:0] dx, dy;
    logic [4:0] adx, ady;
    logic [1:0] dir_x, dir_y, prim, sec, cw, ccw, mv;

    function automatic logic legal(input logic [1:0] d, input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
        return d != (o ^ 2'b10) &&
               (d == UP ? y != 4'd0 : d == RIGHT ? x != XMAX : d == DOWN ? y != YMAX : x != 4'd0);
    endfunction

    assign tick     = bus.vsync & ~vsync_d_q;
    assign step     = tick && bus.enable && state_q != IDLE && cnt_q == PERIOD;
    // a hit in the step cycle already switches this step to retreat rules
    assign hit_live = bus.hit && state_q != IDLE;
    assign eff      = hit_live ? RETREAT : state_q;
    assign rcnt_eff = hit_live ? RSTEPS : rcnt_q;
    assign retreat  = eff == RETREAT;

    assign tx        = bus.target_pos[7:4] > XMAX ? XMAX : bus.target_pos[7:4];
    assign ty        = bus.target_pos[3:0] > YMAX ? YMAX : bus.target_pos[3:0];
    assign at_target = x_q == tx && y_q == ty;
    assign dx        = $signed({1'b0, tx}) - $signed({1'b0, x_q});
    assign dy        = $signed({1'b0, ty}) - $signed({1'b0, y_q});
    assign adx       = dx[4] ? 5'(-dx) : 5'(dx);
    assign ady       = dy[4] ? 5'(-dy) : 5'(dy);
    assign x_primary = adx >= ady;
    assign dir_x     = ((dx > 5'sd0) ^ retreat) ? RIGHT : LEFT;
    assign dir_y     = ((dy > 5'sd0) ^ retreat) ? DOWN : UP;
    assign prim      = x_primary ? dir_x : dir_y;
    assign sec       = x_primary ? dir_y : dir_x;
    assign sec_ok    = retreat || (x_primary ? dy != 5'sd0 : dx != 5'sd0);
    assign cw        = orient_q + 2'd1;
    assign ccw       = orient_q - 2'd1;

    always_comb begin
        mv    = orient_q;
        moved = 1'b1;
        if (legal(prim, orient_q, x_q, y_q)) mv = prim;
        else if (sec_ok && legal(sec, orient_q, x_q, y_q)) mv = sec;
        else if (legal(cw, orient_q, x_q, y_q)) mv = cw;
        else if (legal(ccw, orient_q, x_q, y_q)) mv = ccw;
        else moved = 1'b0;
    end

    always_comb begin
        state_d  = eff;
        rcnt_d   = rcnt_eff;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        orient_d = orient_q;
        if (state_q == IDLE) cnt_d = '0;
        else if (tick) cnt_d = cnt_q == PERIOD ? '0 : cnt_q + 6'd1;
        if (step) begin
            if (retreat) begin
                rcnt_d  = rcnt_eff - 8'd1;
                state_d = rcnt_eff <= 8'd1 ? CHASE : RETREAT;
            end else begin
                state_d = at_target ? HOLD : CHASE;
            end
            if ((retreat || !at_target) && moved) begin
                orient_d = mv;
                x_d      = mv == RIGHT ? x_q + 4'd1 : mv == LEFT ? x_q - 4'd1 : x_q;
                y_d      = mv == DOWN ? y_q + 4'd1 : mv == UP ? y_q - 4'd1 : y_q;
            end
        end
        if (state_q == IDLE) state_d = bus.enable ? CHASE : IDLE;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            orient_q     <= RIGHT;
            x_q          <= 4'(START_X);
            y_q          <= 4'(START_Y);
            cnt_q        <= '0;
            rcnt_q       <= '0;
            vsync_d_q    <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            orient_q     <= orient_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            rcnt_q       <= rcnt_d;
            vsync_d_q    <= bus.vsync;
            step_pulse_q <= step;
        end
    end

    assign bus.Dragon_Head     = {orient_q, x_q, y_q};
    assign bus.movementCounter = cnt_q;
    assign bus.step_pulse      = step_pulse_q;
    assign bus.state_out       = state_q;
endmodule

// File: tb/tb_dragon_head_ctrl.sv
// tb_dragon_head_ctrl: scoreboard bench; stimulus queues expected {state, head} per step, monitors pop on step_pulse
module tb_dragon_head_ctrl;
    localparam logic [1:0] S_I = 2'd0, S_C = 2'd1, S_H = 2'd2, S_R = 2'd3;
    localparam logic [1:0] O_U = 2'd0, O_R = 2'd1, O_D = 2'd2, O_L = 2'd3;

    logic clk = 1'b0;
    logic rst, vs, hit_drv, sel;
    logic [11:0] qa[$], qb[$];
    logic [1:0] pa = 2'b01;
    int n_chk = 0, n_pass = 0;
    int m_x, m_y, m_o, m_st, m_rc;

    dragon_head_if ifa ();
    dragon_head_if ifb ();
    assign ifa.vsync = vs & ~sel;
    assign ifb.vsync = vs & sel;
    assign ifa.hit   = hit_drv & ~sel;
    assign ifb.hit   = hit_drv & sel;

    dragon_head_ctrl dut_a (.clk(clk), .reset(rst), .bus(ifa));
    dragon_head_ctrl #(.START_X(5), .START_Y(5)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [11:0] ex(input logic [1:0] s, input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
        return {s, o, x, y};
    endfunction

    task automatic frame(input bit hit_now);
        vs = 1'b1;
        hit_drv = hit_now;
        @(posedge clk); #1;
        hit_drv = 1'b0;
        @(posedge clk); #1;
        vs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ten counting frames, then the step frame; the expectation is queued only for the step frame
    task automatic do_step(input logic [11:0] e);
        repeat (10) frame(1'b0);
        if (sel) qb.push_back(e);
        else qa.push_back(e);
        frame(1'b0);
        check("step_seen", 32'(sel ? qb.size() : qa.size()), 0);
    endtask

    task automatic model_step(input logic [7:0] tp);
        int tx, ty, dx, dy, nx, ny, xdir, ydir;
        int c[4];
        bit v[4];
        bit rt, xp;
        int ddx[4] = '{0, 1, 0, -1};
        int ddy[4] = '{-1, 0, 1, 0};
        tx = int'(tp[7:4]);
        ty = tp[3:0] > 4'd11 ? 11 : int'(tp[3:0]);
        dx = tx - m_x;
        dy = ty - m_y;
        rt = (m_st == 3);
        if (!rt && dx == 0 && dy == 0) begin
            m_st = 2;
            return;
        end
        if (rt) begin
            m_rc--;
            if (m_rc == 0) m_st = 1;
        end else m_st = 1;
        xp = (dx < 0 ? -dx : dx) >= (dy < 0 ? -dy : dy);
        xdir = rt ? (dx > 0 ? 3 : 1) : (dx > 0 ? 1 : 3);
        ydir = rt ? (dy > 0 ? 0 : 2) : (dy > 0 ? 2 : 0);
        c = '{xp ? xdir : ydir, xp ? ydir : xdir, (m_o + 1) % 4, (m_o + 3) % 4};
        v = '{1'b1, rt || (xp ? dy != 0 : dx != 0), 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            nx = m_x + ddx[c[i]];
            ny = m_y + ddy[c[i]];
            if (v[i] && c[i] != (m_o ^ 2) && nx >= 0 && nx < 16 && ny >= 0 && ny < 12) begin
                m_x = nx;
                m_y = ny;
                m_o = c[i];
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (ifa.step_pulse === 1'b1) begin
            if (qa.size() == 0) begin
                n_chk++;
                $display("FAIL stepA_unexpected: pulse with head %h, none expected", ifa.Dragon_Head);
            end else check("stepA", 32'({ifa.state_out, ifa.Dragon_Head}), 32'(qa.pop_front()));
            check("gridA_y", 32'(ifa.Dragon_Head[3:0] <= 4'd11), 1);
            check("norevA", 32'(ifa.Dragon_Head[9:8] == (pa ^ 2'b10)), 0);
            pa = ifa.Dragon_Head[9:8];
        end
    end

    always @(negedge clk) begin
        if (ifb.step_pulse === 1'b1) begin
            if (qb.size() == 0) begin
                n_chk++;
                $display("FAIL stepB_unexpected: pulse with head %h, none expected", ifb.Dragon_Head);
            end else check("stepB", 32'({ifb.state_out, ifb.Dragon_Head}), 32'(qb.pop_front()));
        end
    end

    initial begin
        int r;
        logic [7:0] tp;
        rst = 1'b1; vs = 1'b0; hit_drv = 1'b0; sel = 1'b0;
        ifa.enable = 1'b1; ifa.target_pos = 8'h82;
        ifb.enable = 1'b0; ifb.target_pos = 8'h25;
        repeat (2) @(posedge clk);
        #1;
        check("rst_headA", 32'(ifa.Dragon_Head), 32'h122);
        check("rst_cntA", 32'(ifa.movementCounter), 0);
        check("rst_stateA", 32'(ifa.state_out), 0);
        check("rst_pulseA", 32'(ifa.step_pulse), 0);
        check("rst_headB", 32'(ifb.Dragon_Head), 32'h155);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_to_chase", 32'(ifa.state_out), 32'(S_C));
        // first period: counter 1..10 on ticks, wrap and step on the 11th
        for (int k = 1; k <= 10; k++) begin
            frame(1'b0);
            check("cnt", 32'(ifa.movementCounter), 32'(k));
        end
        qa.push_back(ex(S_C, O_R, 4'd3, 4'd2));
        frame(1'b0);
        check("step_seen", 32'(qa.size()), 0);
        check("cnt_wrap", 32'(ifa.movementCounter), 0);
        for (int x = 4; x <= 8; x++) do_step(ex(S_C, O_R, 4'(x), 4'd2));
        do_step(ex(S_H, O_R, 4'd8, 4'd2));
        // dut_b: reversal rejected, secondary invalid, clockwise taken; then walk to (0,0)
        sel = 1'b1;
        ifb.enable = 1'b1;
        @(posedge clk); #1;
        do_step(ex(S_C, O_D, 4'd5, 4'd6));
        ifb.target_pos = 8'h00;
        do_step(ex(S_C, O_L, 4'd4, 4'd6));
        do_step(ex(S_C, O_U, 4'd4, 4'd5));
        do_step(ex(S_C, O_U, 4'd4, 4'd4));
        do_step(ex(S_C, O_L, 4'd3, 4'd4));
        do_step(ex(S_C, O_U, 4'd3, 4'd3));
        do_step(ex(S_C, O_L, 4'd2, 4'd3));
        do_step(ex(S_C, O_U, 4'd2, 4'd2));
        do_step(ex(S_C, O_L, 4'd1, 4'd2));
        do_step(ex(S_C, O_U, 4'd1, 4'd1));
        do_step(ex(S_C, O_L, 4'd0, 4'd1));
        do_step(ex(S_C, O_U, 4'd0, 4'd0));
        do_step(ex(S_H, O_U, 4'd0, 4'd0));
        hit_drv = 1'b1;
        @(posedge clk); #1;
        hit_drv = 1'b0;
        check("hit_retreat", 32'(ifb.state_out), 32'(S_R));
        do_step(ex(S_R, O_R, 4'd1, 4'd0));
        do_step(ex(S_R, O_R, 4'd2, 4'd0));
        do_step(ex(S_R, O_R, 4'd3, 4'd0));
        do_step(ex(S_C, O_R, 4'd4, 4'd0));
        do_step(ex(S_C, O_D, 4'd4, 4'd1));
        // disabled: frozen in IDLE for 30 frames, then first step 11 ticks after re-enable
        ifb.enable = 1'b0;
        @(posedge clk); #1;
        repeat (30) frame(1'b0);
        check("dis_cnt", 32'(ifb.movementCounter), 0);
        check("dis_state", 32'(ifb.state_out), 32'(S_I));
        check("dis_head", 32'(ifb.Dragon_Head), 32'h241);
        ifb.enable = 1'b1;
        @(posedge clk); #1;
        do_step(ex(S_C, O_L, 4'd3, 4'd1));
        // dut_a: randomised run against the reference model
        sel = 1'b0;
        m_x = 8; m_y = 2; m_o = 1; m_st = 2; m_rc = 0;
        for (int i = 0; i < 1000; i++) begin
            tp = 8'($urandom_range(0, 255));
            ifa.target_pos = tp;
            r = $urandom_range(0, 15);
            for (int f = 0; f < 10; f++) begin
                frame(1'b0);
                if (r == 0 && f == 4) begin
                    hit_drv = 1'b1;
                    @(posedge clk); #1;
                    hit_drv = 1'b0;
                    m_st = 3;
                    m_rc = 4;
                end
            end
            if (r == 1) begin
                m_st = 3;
                m_rc = 4;
            end
            model_step(tp);
            qa.push_back({2'(m_st), 2'(m_o), 4'(m_x), 4'(m_y)});
            frame(r == 1);
            check("rnd_step_seen", 32'(qa.size()), 0);
        end
        // asynchronous reset mid-period
        repeat (7) frame(1'b0);
        check("cnt7", 32'(ifa.movementCounter), 7);
        #2;
        rst = 1'b1;
        #1;
        check("arst_head", 32'(ifa.Dragon_Head), 32'h122);
        check("arst_cnt", 32'(ifa.movementCounter), 0);
        check("arst_state", 32'(ifa.state_out), 0);
        check("arst_pulse", 32'(ifa.step_pulse), 0);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
